registrador_entrada_tempo: RTL and testbench
============================================

REGISTRADOR_ENTRADA_TEMPO -- requirements
Module: registrador_entrada_tempo

Interface
REQ-001 SHALL have parameter DEBOUNCE_CICLOS, default 4: consecutive cycles loadn must stay low before a key is accepted (legal range 1..255).
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port saida_cod, input, 4: key code from the keypad priority encoder (0..9 valid).
REQ-005 SHALL have port loadn, input, 1: active-low key-present strobe from the encoder.
REQ-006 SHALL have port limpar, input, 1: synchronous clear of the entered time.
REQ-007 SHALL have port trava, input, 1: lock; while high, keys are ignored (cooking in progress).
REQ-008 SHALL have port min_dez, output, 4: BCD minutes tens digit.
REQ-009 SHALL have port min_uni, output, 4: BCD minutes units digit.
REQ-010 SHALL have port seg_dez, output, 4: BCD seconds tens digit.
REQ-011 SHALL have port seg_uni, output, 4: BCD seconds units digit.
REQ-012 SHALL have port num_digitos, output, 3: count of digits entered, 0..4.
REQ-013 SHALL have port digito_aceito, output, 1: one-cycle pulse when a digit is shifted in.
REQ-014 SHALL have port tempo_zero, output, 1: high when all four digits are 0.

Function
REQ-015 SHALL implement FSM states OCIOSO (no key), FILTRANDO (loadn low, counting), SEGURANDO (key accepted, waiting release).
REQ-016 OCIOSO: loadn=0 and trava=0 -> FILTRANDO with filter count=1; otherwise stay.
REQ-017 FILTRANDO: loadn=1 -> OCIOSO, count cleared; loadn=0 and count reaches DEBOUNCE_CICLOS -> accept saida_cod sampled that cycle and go to SEGURANDO.
REQ-018 SEGURANDO: stay while loadn=0; loadn=1 -> OCIOSO; a held key SHALL produce exactly one digit.
REQ-019 Accept: if saida_cod <= 9 and num_digitos < 4, digits shift left (min_dez<=min_uni<=seg_dez<=seg_uni<=saida_cod), num_digitos increments, digito_aceito pulses the cycle after the accepting edge (latency DEBOUNCE_CICLOS cycles from loadn falling).
REQ-020 If saida_cod > 9 or num_digitos = 4, the accept SHALL be discarded: no shift, no pulse, FSM still goes to SEGURANDO.
REQ-021 trava=1 in FILTRANDO SHALL return FSM to OCIOSO with count cleared; trava has no effect in SEGURANDO.
REQ-022 limpar=1 SHALL zero all digits and num_digitos next cycle and suppress any same-cycle accept; FSM state unaffected.
REQ-023 Digits are not range-checked for seconds (e.g. 99 seconds allowed); normalisation is the timer's job.
REQ-024 tempo_zero SHALL be combinational from the digit registers.

Reset
REQ-025 reset=1 SHALL, on the next rising edge, set all digits to 0, num_digitos=0, digito_aceito=0, filter count=0, FSM=OCIOSO; tempo_zero is then 1.
REQ-026 reset SHALL take priority over limpar, trava and any accept, including mid-filter or mid-hold.

Structure
REQ-027 Package microondas_pkg SHALL hold the FSM state enum, the BCD digit width constant (4) and the max digit count constant (4).
REQ-028 The debounce counter and its FSM SHALL be a sub-module filtro_tecla producing a one-cycle accept strobe plus sampled code; the top holds the digit shift register.

Verification
REQ-029 Keys 1,2,3,0 each low 6 cycles with gaps, DEBOUNCE_CICLOS=4 -> digits 1,2,3,0, num_digitos=4, four digito_aceito pulses, tempo_zero=0.
REQ-030 loadn low 3 cycles with code 5 then high -> no change, no pulse.
REQ-031 Key 7 held 50 cycles -> exactly one pulse, seg_uni=7, num_digitos=1.
REQ-032 After 4 digits, key 9 -> digits unchanged, no pulse; then limpar=1 -> all 0, num_digitos=0, tempo_zero=1.
REQ-033 trava=1 with key 4 pressed 10 cycles -> no change; trava dropped at filter cycle 2 -> FSM restarts filter, no accept that press.
REQ-034 reset asserted while in SEGURANDO with digits 0,0,4,5 -> all outputs at reset values next cycle; subsequent key 8 accepted normally after release and re-press.

Source files
------------

// File: rtl/microondas_pkg.sv
// ---------------------------------------------------------------------------
// microondas_pkg
// Shared definitions for the microwave keypad time-entry block.
//   estado_t    : states of the key debounce FSM.
//   LARGURA_BCD : width of one BCD digit.
//   MAX_DIGITOS : number of digits held by the entry register (MM:SS).
// ---------------------------------------------------------------------------
package microondas_pkg;

    localparam int LARGURA_BCD = 4;
    localparam int MAX_DIGITOS = 4;

    // OCIOSO: no key present; FILTRANDO: loadn low, counting;
    // SEGURANDO: key accepted, waiting for release.
    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        FILTRANDO = 2'd1,
        SEGURANDO = 2'd2
    } estado_t;

endpackage

// File: rtl/filtro_tecla.sv
// ---------------------------------------------------------------------------
// filtro_tecla
// Debounces the keypad encoder strobe. A key is accepted once loadn has been
// low (with trava low) for DEBOUNCE_CICLOS consecutive sampled cycles; after
// that the key is held until loadn returns high, so one press yields exactly
// one accept.
// Ports:
//   clock      : rising-edge clock
//   reset      : synchronous, active-high reset
//   loadn_i    : active-low key-present strobe
//   trava_i    : lock; aborts an ongoing filter and blocks new presses
//   codigo_i   : key code from the encoder
//   aceite_o   : one-cycle accept strobe, valid in the accepting cycle
//   codigo_o   : key code to be captured on the accepting edge
// ---------------------------------------------------------------------------
module filtro_tecla
    import microondas_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   loadn_i,
    input  logic                   trava_i,
    input  logic [LARGURA_BCD-1:0] codigo_i,
    output logic                   aceite_o,
    output logic [LARGURA_BCD-1:0] codigo_o
);

    // Count value held in the cycle in which the last required low sample
    // arrives; reaching it while loadn is still low completes the filter.
    localparam logic [7:0] ULTIMA = 8'(DEBOUNCE_CICLOS - 1);

    estado_t    estado_q, estado_d;
    logic [7:0] contagem_q, contagem_d;

    // The strobe is decoded from the current state and inputs so that the
    // digit register can capture the code on the very edge that completes
    // the filter, giving a pulse exactly DEBOUNCE_CICLOS cycles after loadn
    // falls.
    always_comb begin
        estado_d   = estado_q;
        contagem_d = contagem_q;
        aceite_o   = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (!loadn_i && !trava_i) begin
                    if (ULTIMA == 8'd0) begin
                        // Single-cycle filter: the first low sample suffices.
                        aceite_o   = 1'b1;
                        estado_d   = SEGURANDO;
                        contagem_d = 8'd0;
                    end else begin
                        estado_d   = FILTRANDO;
                        contagem_d = 8'd1;
                    end
                end
            end
            FILTRANDO: begin
                if (loadn_i || trava_i) begin
                    estado_d   = OCIOSO;
                    contagem_d = 8'd0;
                end else if (contagem_q == ULTIMA) begin
                    aceite_o   = 1'b1;
                    estado_d   = SEGURANDO;
                    contagem_d = 8'd0;
                end else begin
                    contagem_d = contagem_q + 8'd1;
                end
            end
            SEGURANDO: begin
                if (loadn_i) begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d   = OCIOSO;
                contagem_d = 8'd0;
            end
        endcase
    end

    // State and filter count registers; reset wins over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            contagem_q <= 8'd0;
        end else begin
            estado_q   <= estado_d;
            contagem_q <= contagem_d;
        end
    end

    assign codigo_o = codigo_i;

endmodule

// File: rtl/registrador_entrada_tempo.sv
// ---------------------------------------------------------------------------
// registrador_entrada_tempo
// Collects up to four BCD digits typed on the keypad into an MM:SS shift
// register. New digits enter at seg_uni and push older ones towards min_dez.
// Seconds are not range-checked here; the timer normalises them.
// Ports:
//   clock         : rising-edge clock
//   reset         : synchronous, active-high reset
//   saida_cod     : key code from the priority encoder (0..9 valid)
//   loadn         : active-low key-present strobe
//   limpar        : synchronous clear of the entered time
//   trava         : lock; keys are ignored while high
//   min_dez..seg_uni : BCD digits of the entered time
//   num_digitos   : number of digits entered (0..4)
//   digito_aceito : one-cycle pulse when a digit is shifted in
//   tempo_zero    : high when all four digits are zero
// ---------------------------------------------------------------------------
module registrador_entrada_tempo
    import microondas_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [LARGURA_BCD-1:0] saida_cod,
    input  logic                   loadn,
    input  logic                   limpar,
    input  logic                   trava,
    output logic [LARGURA_BCD-1:0] min_dez,
    output logic [LARGURA_BCD-1:0] min_uni,
    output logic [LARGURA_BCD-1:0] seg_dez,
    output logic [LARGURA_BCD-1:0] seg_uni,
    output logic [2:0]             num_digitos,
    output logic                   digito_aceito,
    output logic                   tempo_zero
);

    localparam int LARGURA_REG = MAX_DIGITOS * LARGURA_BCD;

    logic                   aceite;
    logic [LARGURA_BCD-1:0] codigo;

    logic [LARGURA_REG-1:0] digitos_q, digitos_d;
    logic [2:0]             num_q, num_d;
    logic                   aceito_q, aceito_d;

    filtro_tecla #(
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS)
    ) u_filtro (
        .clock    (clock),
        .reset    (reset),
        .loadn_i  (loadn),
        .trava_i  (trava),
        .codigo_i (saida_cod),
        .aceite_o (aceite),
        .codigo_o (codigo)
    );

    // Clear has precedence over an accept in the same cycle. Invalid codes
    // and accepts into a full register are dropped silently; the filter
    // still moves to its hold state so the press is consumed.
    always_comb begin
        digitos_d = digitos_q;
        num_d     = num_q;
        aceito_d  = 1'b0;
        if (limpar) begin
            digitos_d = '0;
            num_d     = 3'd0;
        end else if (aceite && (codigo <= 4'd9) && (num_q < 3'(MAX_DIGITOS))) begin
            digitos_d = {digitos_q[LARGURA_REG-LARGURA_BCD-1:0], codigo};
            num_d     = num_q + 3'd1;
            aceito_d  = 1'b1;
        end
    end

    // Digit, count and pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            digitos_q <= '0;
            num_q     <= 3'd0;
            aceito_q  <= 1'b0;
        end else begin
            digitos_q <= digitos_d;
            num_q     <= num_d;
            aceito_q  <= aceito_d;
        end
    end

    assign min_dez       = digitos_q[15:12];
    assign min_uni       = digitos_q[11:8];
    assign seg_dez       = digitos_q[7:4];
    assign seg_uni       = digitos_q[3:0];
    assign num_digitos   = num_q;
    assign digito_aceito = aceito_q;
    assign tempo_zero    = (digitos_q == '0);

endmodule

// File: tb/tb_registrador_entrada_tempo.sv
// ---------------------------------------------------------------------------
// tb_registrador_entrada_tempo
// Self-checking bench: table of key presses with hand-derived expectations,
// hand-written corner sequences, and randomized traffic compared every cycle
// against a reference model that tracks key-press run lengths and keeps the
// entered digits in a queue.
// ---------------------------------------------------------------------------
module tb_registrador_entrada_tempo;

    localparam int D = 4;

    logic       clock;
    logic       reset;
    logic [3:0] saida_cod;
    logic       loadn;
    logic       limpar;
    logic       trava;
    logic [3:0] min_dez, min_uni, seg_dez, seg_uni;
    logic [2:0] num_digitos;
    logic       digito_aceito;
    logic       tempo_zero;

    int nCompared   = 0;
    int nMismatched = 0;
    int pulseCount  = 0;

    // Reference model state.
    int  mRun   = 0;
    bit  mHeld  = 0;
    bit  mPulse = 0;
    int  mList[$];

    registrador_entrada_tempo #(
        .DEBOUNCE_CICLOS (D)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .saida_cod     (saida_cod),
        .loadn         (loadn),
        .limpar        (limpar),
        .trava         (trava),
        .min_dez       (min_dez),
        .min_uni       (min_uni),
        .seg_dez       (seg_dez),
        .seg_uni       (seg_uni),
        .num_digitos   (num_digitos),
        .digito_aceito (digito_aceito),
        .tempo_zero    (tempo_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One comparison; a mismatch prints a single FAIL line.
    task automatic checkOutput(input string nome, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", nome, got, exp);
        end
    endtask

    function automatic logic [15:0] dutDigits();
        return {min_dez, min_uni, seg_dez, seg_uni};
    endfunction

    // Expected output vector: the queue's last entries right-aligned, with
    // leading zero digits for positions not yet typed.
    function automatic logic [20:0] modelVec();
        logic [15:0] d;
        int off;
        d   = '0;
        off = 4 - mList.size();
        for (int i = 0; i < 4; i++) begin
            if (i >= off) d[15-4*i -: 4] = 4'(mList[i-off]);
        end
        return {d, 3'(mList.size()), mPulse, (d == 16'h0)};
    endfunction

    // A key is taken once it has been low with trava low for D consecutive
    // samples since it was last released; a press yields at most one key.
    task automatic modelUpdate();
        bit acc;
        acc = 0;
        if (reset) begin
            mRun = 0; mHeld = 0; mPulse = 0;
            mList.delete();
        end else begin
            if (loadn) begin
                mRun = 0; mHeld = 0;
            end else if (!mHeld) begin
                if (trava) mRun = 0;
                else begin
                    mRun++;
                    if (mRun == D) begin acc = 1; mHeld = 1; mRun = 0; end
                end
            end
            mPulse = 0;
            if (limpar) mList.delete();
            else if (acc && saida_cod <= 4'd9 && mList.size() < 4) begin
                mList.push_back(int'(saida_cod));
                mPulse = 1;
            end
        end
    endtask

    // Advance one clock with the current inputs and compare against the model.
    task automatic applyStimulus();
        modelUpdate();
        @(posedge clock);
        #1;
        if (digito_aceito) pulseCount++;
        checkOutput("modelo", {dutDigits(), num_digitos, digito_aceito, tempo_zero}, modelVec());
    endtask

    task automatic pressKey(input logic [3:0] c, input int low, input int gap);
        pulseCount = 0;
        loadn      = 1'b0;
        saida_cod  = c;
        repeat (low) applyStimulus();
        loadn = 1'b1;
        repeat (gap) applyStimulus();
    endtask

    typedef struct {
        string       nome;
        bit          limparAntes;
        logic [3:0]  cod;
        int          low;
        logic [15:0] expDig;
        int          expN;
        int          expPulses;
    } press_t;

    press_t tab[8];

    initial begin
        int runLeft;

        tab[0] = '{"k1",      1'b0, 4'd1,  6,  16'h0001, 1, 1};
        tab[1] = '{"k2",      1'b0, 4'd2,  6,  16'h0012, 2, 1};
        tab[2] = '{"k3",      1'b0, 4'd3,  6,  16'h0123, 3, 1};
        tab[3] = '{"k0",      1'b0, 4'd0,  6,  16'h1230, 4, 1};
        tab[4] = '{"k9_full", 1'b0, 4'd9,  6,  16'h1230, 4, 0};
        tab[5] = '{"k5_short",1'b1, 4'd5,  3,  16'h0000, 0, 0};
        tab[6] = '{"k7_held", 1'b0, 4'd7,  50, 16'h0007, 1, 1};
        tab[7] = '{"kE_inval",1'b0, 4'd14, 6,  16'h0007, 1, 0};

        reset = 1'b1; loadn = 1'b1; limpar = 1'b0; trava = 1'b0; saida_cod = 4'd0;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_state", {dutDigits(), num_digitos, digito_aceito, tempo_zero},
                    {16'h0, 3'd0, 1'b0, 1'b1});
        reset = 1'b0;
        applyStimulus();

        for (int i = 0; i < 8; i++) begin
            if (tab[i].limparAntes) begin
                limpar = 1'b1;
                applyStimulus();
                limpar = 1'b0;
                checkOutput("limpar_clear", {dutDigits(), num_digitos, tempo_zero},
                            {16'h0, 3'd0, 1'b1});
            end
            pressKey(tab[i].cod, tab[i].low, 4);
            checkOutput({tab[i].nome, "_dig"}, dutDigits(), tab[i].expDig);
            checkOutput({tab[i].nome, "_n"}, num_digitos, tab[i].expN);
            checkOutput({tab[i].nome, "_pulses"}, pulseCount, tab[i].expPulses);
            if (i == 3) checkOutput("k0_tempo_zero", tempo_zero, 1'b0);
        end

        // Key pressed while locked is ignored.
        trava = 1'b1;
        pressKey(4'd4, 10, 4);
        trava = 1'b0;
        checkOutput("trava_dig", dutDigits(), 16'h0007);
        checkOutput("trava_pulses", pulseCount, 0);

        // Lock pulsed mid-filter restarts it; the remaining 3 low samples
        // are too few to accept.
        pulseCount = 0;
        loadn = 1'b0; saida_cod = 4'd4;
        applyStimulus(); applyStimulus();
        trava = 1'b1; applyStimulus();
        trava = 1'b0;
        repeat (3) applyStimulus();
        loadn = 1'b1;
        repeat (4) applyStimulus();
        checkOutput("restart_dig", dutDigits(), 16'h0007);
        checkOutput("restart_pulses", pulseCount, 0);

        // Reset while a key is held after digits 0,0,4,5 were entered.
        limpar = 1'b1; applyStimulus(); limpar = 1'b0;
        pressKey(4'd4, 6, 4);
        pulseCount = 0;
        loadn = 1'b0; saida_cod = 4'd5;
        repeat (6) applyStimulus();
        checkOutput("pre_reset_dig", dutDigits(), 16'h0045);
        reset = 1'b1;
        applyStimulus();
        checkOutput("hold_reset", {dutDigits(), num_digitos, digito_aceito, tempo_zero},
                    {16'h0, 3'd0, 1'b0, 1'b1});
        reset = 1'b0; loadn = 1'b1;
        repeat (4) applyStimulus();
        pressKey(4'd8, 6, 4);
        checkOutput("k8_dig", dutDigits(), 16'h0008);
        checkOutput("k8_n", num_digitos, 1);
        checkOutput("k8_pulses", pulseCount, 1);

        // Randomized traffic against the model.
        runLeft = 0;
        for (int c = 0; c < 2000; c++) begin
            if (runLeft == 0) begin
                loadn   = ~loadn;
                runLeft = $urandom_range(1, 9);
                if (!loadn) saida_cod = 4'($urandom_range(0, 11));
            end
            trava  = ($urandom_range(0, 9) == 0);
            limpar = ($urandom_range(0, 29) == 0);
            reset  = ($urandom_range(0, 199) == 0);
            applyStimulus();
            runLeft--;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
